// File: rtl/gray_code_pkg.sv
// Shared types, constants and the binary-to-Gray helper for the Gray counter.
package gray_code_pkg;

  // Widest counter the helper function supports; callers zero-extend into it.
  localparam int unsigned MAX_SIZE = 32;

  // Reference fill constants; each counter narrows these to its own SIZE.
  localparam logic [MAX_SIZE-1:0] MAX_ZERO     = '0;
  localparam logic [MAX_SIZE-1:0] MAX_ALL_ONES = '1;

  // Per-cycle action chosen by the priority mux; reset is handled in the register.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_STEP = 2'd1,
    OP_LOAD = 2'd2
  } op_e;

  // Reflected binary Gray code of a zero-extended value.
  function automatic logic [MAX_SIZE-1:0] bin2gray(input logic [MAX_SIZE-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/binary_to_gray_ds.sv
// Purely combinational SIZE-bit binary-to-Gray encoder.
module binary_to_gray_ds
  import gray_code_pkg::*;
#(
  parameter int unsigned SIZE = 4
) (
  input  logic [SIZE-1:0] bin,
  output logic [SIZE-1:0] gray
);

  // Widen into the helper's domain and narrow the result back to SIZE bits.
  always_comb begin
    gray = SIZE'(bin2gray(MAX_SIZE'(bin)));
  end

endmodule

// File: rtl/gray_code_counter.sv
// Registered binary-to-Gray encoder around a modulo-2^SIZE binary counter.
// Optional macro BIN_TO_GRAY_UPDOWN_EN adds the up port and decrement support;
// without it the counter increments only.
module gray_code_counter
  import gray_code_pkg::*;
#(
  parameter int unsigned SIZE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
`ifdef BIN_TO_GRAY_UPDOWN_EN
  input  logic            up,
`endif
  input  logic            load,
  input  logic [SIZE-1:0] load_bin,
  output logic [SIZE-1:0] bin,
  output logic [SIZE-1:0] gray,
  output logic            wrap
);

  localparam logic [SIZE-1:0] ZERO     = SIZE'(MAX_ZERO);
  localparam logic [SIZE-1:0] ALL_ONES = SIZE'(MAX_ALL_ONES);

  op_e             op;
  logic [SIZE-1:0] bin_nxt;
  logic [SIZE-1:0] gray_nxt;
  logic            wrap_nxt;

  // Priority decode below reset: load beats count enable, otherwise hold.
  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (en) begin
      op = OP_STEP;
    end
  end

  // Next binary value and boundary-crossing flag for the selected action.
  always_comb begin
    bin_nxt  = bin;
    wrap_nxt = 1'b0;
    case (op)
      OP_LOAD: begin
        bin_nxt = load_bin;
      end
      OP_STEP: begin
`ifdef BIN_TO_GRAY_UPDOWN_EN
        if (up) begin
          bin_nxt  = bin + 1'b1;
          wrap_nxt = (bin == ALL_ONES);
        end else begin
          bin_nxt  = bin - 1'b1;
          wrap_nxt = (bin == ZERO);
        end
`else
        bin_nxt  = bin + 1'b1;
        wrap_nxt = (bin == ALL_ONES);
`endif
      end
      default: begin
        bin_nxt  = bin;
        wrap_nxt = 1'b0;
      end
    endcase
  end

  // Gray is encoded from the next-state binary so both registers always agree.
  binary_to_gray_ds #(
    .SIZE(SIZE)
  ) u_enc (
    .bin  (bin_nxt),
    .gray (gray_nxt)
  );

  // Output registers with synchronous active-low reset taking top priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin  <= ZERO;
      gray <= ZERO;
      wrap <= 1'b0;
    end else begin
      bin  <= bin_nxt;
      gray <= gray_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_gray_code_counter.sv
// Self-checking bench for gray_code_counter (SIZE=4), default or up/down build.
module tb_gray_code_counter;

  localparam int SIZE = 4;
  localparam int MOD  = 1 << SIZE;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            up;
  logic            load;
  logic [SIZE-1:0] load_bin;
  logic [SIZE-1:0] bin;
  logic [SIZE-1:0] gray;
  logic            wrap;

  int checks = 0;
  int errors = 0;

  gray_code_counter #(
    .SIZE(SIZE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
`ifdef BIN_TO_GRAY_UPDOWN_EN
    .up       (up),
`endif
    .load     (load),
    .load_bin (load_bin),
    .bin      (bin),
    .gray     (gray),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_bin     = 0;
  bit m_wrap    = 1'b0;
  bit m_counted = 1'b0;
  bit m_valid   = 1'b0;

  always @(posedge clk) begin
    bit dir_up;
`ifdef BIN_TO_GRAY_UPDOWN_EN
    dir_up = (up === 1'b1);
`else
    dir_up = 1'b1;
`endif
    m_counted = 1'b0;
    if (rst_n === 1'b0) begin
      m_bin  = 0;
      m_wrap = 1'b0;
    end else if (load === 1'b1) begin
      m_bin  = int'(load_bin);
      m_wrap = 1'b0;
    end else if (en === 1'b1) begin
      m_counted = 1'b1;
      if (dir_up) begin
        m_wrap = (m_bin == MOD - 1);
        m_bin  = (m_bin + 1) % MOD;
      end else begin
        m_wrap = (m_bin == 0);
        m_bin  = (m_bin + MOD - 1) % MOD;
      end
    end else begin
      m_wrap = 1'b0;
    end
    m_valid = 1'b1;
  end

  function automatic int gray_of(input int v);
    return v ^ (v >> 1);
  endfunction

  // Independent Gray-to-binary decoder (prefix XOR from the MSB down).
  function automatic logic [SIZE-1:0] decode(input logic [SIZE-1:0] g);
    logic [SIZE-1:0] b;
    b[SIZE-1] = g[SIZE-1];
    for (int i = SIZE - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic [SIZE-1:0] prev_gray;
  bit              have_prev = 1'b0;

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_bin", int'(bin), m_bin);
      check("model_gray", int'(gray), gray_of(m_bin));
      check("model_wrap", int'(wrap), int'(m_wrap));
      check("decode_eq_bin", int'(decode(gray)), int'(bin));
      if (m_counted && have_prev)
        check("one_bit_step", $countones(gray ^ prev_gray), 1);
      prev_gray = gray;
      have_prev = 1'b1;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input logic r, input logic l, input logic e, input logic u,
                      input logic [SIZE-1:0] lb);
    rst_n    = r;
    load     = l;
    en       = e;
    up       = u;
    load_bin = lb;
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string name, input int b, input int g, input int w);
    check({name, "_bin"},  int'(bin),  b);
    check({name, "_gray"}, int'(gray), g);
    check({name, "_wrap"}, int'(wrap), w);
  endtask

  int t1_gray [4] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};

  initial begin
    rst_n = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; load_bin = '0;

    // Reset, with load and en asserted to show reset wins.
    tick(1'b0, 1'b1, 1'b1, 1'b1, 4'b1010);
    expect_out("reset", 0, 0, 0);

    // Count up four steps from zero.
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 1'b1, 1'b1, '0);
      expect_out("t1_up", i + 1, t1_gray[i], 0);
    end

    // Load all-ones, then wrap to zero for exactly one cycle.
    tick(1'b1, 1'b1, 1'b0, 1'b1, 4'b1111);
    expect_out("t2_load", 4'b1111, 4'b1000, 0);
    tick(1'b1, 1'b0, 1'b1, 1'b1, '0);
    expect_out("t2_wrap", 4'b0000, 4'b0000, 1);
    tick(1'b1, 1'b0, 1'b0, 1'b1, '0);
    expect_out("t2_hold", 4'b0000, 4'b0000, 0);

`ifdef BIN_TO_GRAY_UPDOWN_EN
    // Decrement across zero, then one more step.
    tick(1'b1, 1'b0, 1'b1, 1'b0, '0);
    expect_out("t3_dn_wrap", 4'b1111, 4'b1000, 1);
    tick(1'b1, 1'b0, 1'b1, 1'b0, '0);
    expect_out("t3_dn", 4'b1110, 4'b1001, 0);
`endif

    // Load and enable on the same edge: load wins, no step.
    tick(1'b1, 1'b1, 1'b1, 1'b1, 4'b0101);
    expect_out("t4_load_en", 4'b0101, 4'b0111, 0);

    // Step to 0110, reset mid-count with en high, then resume.
    tick(1'b1, 1'b0, 1'b1, 1'b1, '0);
    expect_out("t5_count", 4'b0110, 4'b0101, 0);
    tick(1'b0, 1'b0, 1'b1, 1'b1, '0);
    expect_out("t5_reset", 0, 0, 0);
    tick(1'b1, 1'b0, 1'b1, 1'b1, '0);
    expect_out("t5_resume", 4'b0001, 4'b0001, 0);

    // Free-run 40 increments from 1: ends at 41 mod 16 = 9.
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0, 1'b1, 1'b1, '0);
    expect_out("t6_end", 4'b1001, 4'b1101, 0);

    // Hold keeps value and clears wrap.
    tick(1'b1, 1'b0, 1'b0, 1'b1, '0);
    expect_out("hold", 4'b1001, 4'b1101, 0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
